// File: rtl/uart_rx_if.sv
// uart_rx_if: consumer-side handshake of the UART receiver's holding register.
interface uart_rx_if;
    logic       rd_en;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun_err;
    modport master (input rd_en, output rx_done_tick, dout, rx_valid, frame_err, overrun_err);
    modport slave (output rd_en, input rx_done_tick, dout, rx_valid, frame_err, overrun_err);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with a one-entry holding register.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       s_tick,
    uart_rx_if.master  bus
);
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam logic [SW-1:0] S_MID  = SW'(7);
    localparam logic [SW-1:0] S_BIT  = SW'(15);
    localparam logic [SW-1:0] S_LAST = SW'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [SW-1:0] s;
    logic [2:0]    n;
    logic [7:0]    b;
    logic [1:0]    sync;
    logic          rx_s;
    logic          done;

    assign rx_s             = sync[1];
    assign done             = (state == STOP) && s_tick && (s == S_LAST);
    assign bus.rx_done_tick = done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            s               <= '0;
            n               <= '0;
            b               <= '0;
            sync            <= 2'b11;
            bus.dout        <= '0;
            bus.rx_valid    <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.overrun_err <= 1'b0;
        end else begin
            sync <= {sync[0], rx};
            case (state)
                IDLE: if (!rx_s) begin
                    state <= START;
                    s     <= '0;
                end
                START: if (s_tick) begin
                    if (s == S_MID) begin
                        state <= rx_s ? IDLE : DATA;
                        s     <= '0;
                        n     <= '0;
                    end else s <= s + 1'b1;
                end
                DATA: if (s_tick) begin
                    if (s == S_BIT) begin
                        s     <= '0;
                        b     <= {rx_s, b[7:1]};
                        state <= (n == N_LAST) ? STOP : DATA;
                        n     <= (n == N_LAST) ? n : n + 1'b1;
                    end else s <= s + 1'b1;
                end
                STOP: if (s_tick) begin
                    if (s == S_LAST) state <= IDLE;
                    else s <= s + 1'b1;
                end
            endcase
            // A read in the completion cycle consumes the old byte, so no overrun.
            if (done) begin
                bus.dout        <= b >> (8 - DBIT);
                bus.frame_err   <= ~rx_s;
                bus.rx_valid    <= 1'b1;
                bus.overrun_err <= bus.rx_valid & ~bus.rd_en;
            end else if (bus.rd_en && bus.rx_valid) begin
                bus.rx_valid    <= 1'b0;
                bus.overrun_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frames against a frame-level model of the receiver's holding register.
module tb_uart_rx;
    logic clk = 1'b0, reset_n = 1'b0, s_tick = 1'b0, rx0 = 1'b1, rx1 = 1'b1;
    int checks = 0, errors = 0, cyc = 0;
    int fall_cyc[2], tick_cnt[2], lat[2], done_cnt[2];
    logic m_valid[2], m_fe[2], m_ovr[2];
    logic [7:0] m_dout[2];

    uart_rx_if if0();
    uart_rx_if if1();

    uart_rx dut0 (.clk(clk), .reset_n(reset_n), .rx(rx0), .s_tick(s_tick), .bus(if0));
    uart_rx #(.DBIT(7), .SB_TICK(32)) dut1 (.clk(clk), .reset_n(reset_n), .rx(rx1), .s_tick(s_tick), .bus(if1));

    always #5 clk = ~clk;

    initial forever begin
        repeat (3) @(negedge clk);
        s_tick = 1'b1;
        @(negedge clk);
        s_tick = 1'b0;
    end

    // Ticks are counted from the first clk the FSM can act on the start edge (2-flop sync + idle).
    initial forever begin
        @(negedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (cyc == fall_cyc[d]) tick_cnt[d] = 0;
            else if (cyc >= fall_cyc[d] + 3 && s_tick) tick_cnt[d]++;
        end
        if (if0.rx_done_tick) begin lat[0] = tick_cnt[0]; done_cnt[0]++; end
        if (if1.rx_done_tick) begin lat[1] = tick_cnt[1]; done_cnt[1]++; end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input int d, input string tag);
        check({tag, ".dout"}, d ? if1.dout : if0.dout, m_dout[d]);
        check({tag, ".valid"}, d ? if1.rx_valid : if0.rx_valid, m_valid[d]);
        check({tag, ".ferr"}, d ? if1.frame_err : if0.frame_err, m_fe[d]);
        check({tag, ".ovr"}, d ? if1.overrun_err : if0.overrun_err, m_ovr[d]);
    endtask

    task automatic drive(input int d, input logic v);
        if (d == 0) rx0 = v;
        else rx1 = v;
    endtask

    task automatic wait_ticks(input int k);
        repeat (4 * k) @(negedge clk);
    endtask

    task automatic do_read(input int d);
        @(negedge clk);
        if (d == 0) if0.rd_en = 1'b1; else if1.rd_en = 1'b1;
        @(negedge clk);
        if (d == 0) if0.rd_en = 1'b0; else if1.rd_en = 1'b0;
        if (m_valid[d]) begin
            m_valid[d] = 1'b0;
            m_ovr[d]   = 1'b0;
        end
    endtask

    task automatic send_frame(input int d, input logic [7:0] data, input logic stop_ok, input logic rd_same);
        int dbit, sbt, base;
        logic hit;
        string tag;
        dbit = d ? 7 : 8;
        sbt  = d ? 32 : 16;
        base = done_cnt[d];
        hit  = 1'b0;
        tag  = $sformatf("d%0d_%02h", d, data);
        @(negedge clk);
        drive(d, 1'b0);
        fall_cyc[d] = cyc + 1;
        fork
            begin
                wait_ticks(16);
                for (int i = 0; i < dbit; i++) begin
                    drive(d, data[i]);
                    wait_ticks(16);
                end
                drive(d, stop_ok);
                if (stop_ok) wait_ticks(sbt);
                else begin
                    wait_ticks(10);
                    drive(d, 1'b1);
                    wait_ticks(16);
                end
                drive(d, 1'b1);
                wait_ticks(4);
            end
            if (rd_same) begin
                for (int i = 0; i < 1000 && !hit; i++) begin
                    @(negedge clk);
                    #1;
                    if (if0.rx_done_tick) begin
                        hit = 1'b1;
                        if0.rd_en = 1'b1;
                        @(negedge clk);
                        if0.rd_en = 1'b0;
                    end
                end
            end
        join
        if (rd_same) check({tag, ".rd_hit"}, 32'(hit), 1);
        check({tag, ".pulses"}, done_cnt[d] - base, 1);
        check({tag, ".latency"}, lat[d], 152);
        m_ovr[d]   = m_valid[d] & ~rd_same;
        m_valid[d] = 1'b1;
        m_dout[d]  = data & (d ? 8'h7f : 8'hff);
        m_fe[d]    = ~stop_ok;
        check_state(d, tag);
    endtask

    initial begin
        int base;
        logic [7:0] pd;
        if0.rd_en = 1'b0;
        if1.rd_en = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0; m_fe[d] = 1'b0; m_ovr[d] = 1'b0; m_dout[d] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check_state(0, "reset0");
        check_state(1, "reset1");
        check("reset.done", 32'(if0.rx_done_tick), 0);
        reset_n = 1'b1;
        wait_ticks(4);

        base = done_cnt[0];
        @(negedge clk);
        drive(0, 1'b0);
        wait_ticks(5);
        drive(0, 1'b1);
        wait_ticks(16);
        check("glitch.pulses", done_cnt[0] - base, 0);
        check("glitch.valid", 32'(if0.rx_valid), 0);

        send_frame(0, 8'hA3, 1'b1, 1'b0);
        do_read(0);
        send_frame(0, 8'h55, 1'b1, 1'b0);
        do_read(0);
        send_frame(0, 8'hF0, 1'b0, 1'b0);
        do_read(0);
        send_frame(0, 8'h0F, 1'b1, 1'b0);
        do_read(0);
        send_frame(0, 8'h11, 1'b1, 1'b0);
        send_frame(0, 8'h22, 1'b1, 1'b0);
        do_read(0);
        check_state(0, "after_read");
        send_frame(0, 8'h33, 1'b1, 1'b1);
        do_read(0);
        send_frame(1, 8'h5A, 1'b1, 1'b0);

        for (int k = 0; k < 16; k++) begin
            int d;
            d = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1) do_read(d);
            send_frame(d, 8'($urandom), d == 1 || $urandom_range(0, 4) != 0, 1'b0);
        end

        send_frame(0, 8'h99, 1'b1, 1'b0);
        pd = 8'hF3;
        @(negedge clk);
        drive(0, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            drive(0, pd[i]);
            wait_ticks(16);
        end
        drive(0, pd[4]);
        wait_ticks(8);
        base = done_cnt[0];
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0; m_fe[d] = 1'b0; m_ovr[d] = 1'b0; m_dout[d] = 8'h00;
        end
        check_state(0, "midreset0");
        check_state(1, "midreset1");
        check("midreset.done", 32'(if0.rx_done_tick), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_ticks(8);
        for (int i = 5; i < 8; i++) begin
            drive(0, pd[i]);
            wait_ticks(16);
        end
        drive(0, 1'b1);
        wait_ticks(20);
        check("midreset.pulses", done_cnt[0] - base, 0);
        check("midreset.valid", 32'(if0.rx_valid), 0);
        send_frame(0, 8'hC3, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for the 16x-oversampled serial interface: the receiving end of the line driven by the codebase's UART transmitter.
- Synchronizes the asynchronous `rx` pin and validates the start bit at mid-bit. Samples data LSB-first at bit centres and checks the stop bit.
- Presents each received byte in a one-entry holding register with valid/read handshake, framing-error and overrun flags.
- Shares `s_tick` with the transmitter from the common baud-rate generator (16 ticks per bit).

Parameters:
DBIT, 8, number of data bits per frame (legal 5..8)
SB_TICK, 16, s_tick count for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
s_tick  input  1  one-clk oversample strobe, 16 per bit period
rd_en  input  1  consumer read strobe; pops the holding register
rx_done_tick  output  1  one-clk pulse when a frame completes (good or bad)
dout  output  8  received data, right-justified, upper 8-DBIT bits zero
rx_valid  output  1  holding register contains an unread frame
frame_err  output  1  stop bit of the frame in dout was sampled low
overrun_err  output  1  sticky: a completed frame overwrote an unread one

Behaviour:
- Reset (`reset_n` low, asynchronous):
  - State = idle; s, n and shift counters = 0.
  - Both synchronizer flops = 1.
  - dout = 0; rx_valid, frame_err, overrun_err and rx_done_tick = 0.
  - Reset mid-frame discards the partial frame with no pulse.
- Input sync: 2-flop synchronizer. rx_s is the second flop; all FSM decisions use rx_s (2-clk pin-to-FSM latency).
- FSM states: idle, start, data, stop. Counters: s (4 bits; wide enough for SB_TICK-1) and n (3 bits). Shift register b (8 bits).
  - idle:
    - rx_s==0 -> start, s=0. No s_tick required.
  - start: on s_tick:
    - s==7 and rx_s==0 -> data, s=0, n=0.
    - s==7 and rx_s==1 -> idle (glitch rejected, no pulse, no flag).
    - otherwise s++.
  - data: on s_tick:
    - s==15 -> s=0, b={rx_s,b[7:1]}. Then n==DBIT-1 -> stop, else n++.
    - otherwise s++.
  - stop: on s_tick:
    - s==SB_TICK-1 -> idle, rx_done_tick=1 for that clk.
    - otherwise s++.
  - Without s_tick, counters hold in every state except idle.
- rx_done_tick: combinational (Mealy), high only in the clk where the final stop s_tick is accepted.
- Completion edge (same rising edge that rx_done_tick is high before):
  - dout <= b>>(8-DBIT).
  - frame_err <= ~rx_s.
  - rx_valid <= 1.
  - Data is loaded even on a framing error.
- Handshake:
  - rd_en with rx_valid=1 and no completion: rx_valid <= 0, overrun_err <= 0. dout and frame_err hold.
  - rd_en with rx_valid=0: ignored.
  - Completion with rx_valid=1 and rd_en=0: overwrite dout/frame_err, overrun_err <= 1.
  - Completion and rd_en in the same clk: new frame loaded, rx_valid stays 1, overrun_err <= 0. Read wins; no overrun.
- Back-to-back frames: after stop, idle may detect the next start on the very next clk. There is no dead time.
- Line held low (break): repeated frames of 0x00, each with frame_err=1. Overrun flags if not read.

Test Plan:
- Single frame, clk:s_tick=4:1, 0x55 sent LSB-first with 1 stop bit:
  - rx_done_tick pulses exactly once, 2 clks plus (16+8*16+16-8) ticks after the falling edge.
  - dout=0x55, rx_valid=1, frame_err=0.
- Glitch: rx low for 5 ticks, then high -> no rx_done_tick, FSM back in idle by tick 7, rx_valid stays 0. A following 0xA3 frame is received correctly.
- Framing error: 0xF0 with stop bit driven low -> dout=0xF0, frame_err=1, rx_valid=1. A subsequent good 0x0F frame with rd_en in between -> frame_err=0.
- Overrun and simultaneity:
  - 0x11 then 0x22 with no rd_en -> dout=0x22, overrun_err=1.
  - rd_en pulse -> rx_valid=0, overrun_err=0.
  - Third frame 0x33 with rd_en coincident with rx_done_tick -> rx_valid=1, dout=0x33, overrun_err=0.
- DBIT=7, SB_TICK=32: 7-bit frame 0x5A with 2 stop bits -> dout=0x5A (bit 7 = 0), pulse after 2-bit stop.
- Reset_n asserted mid data bit 4 of a frame -> all outputs 0 immediately (asynchronous). After release, the remainder of that frame does not produce a valid byte. The next full frame 0xC3 is received correctly.
